// File: rtl/obi_pkg.sv
// Shared OBI types and widths for the memory responder and its response pipeline.
package obi_pkg;

    localparam int unsigned OBI_ADDR_W = 32;
    localparam int unsigned OBI_DATA_W = 32;
    localparam int unsigned OBI_BE_W   = OBI_DATA_W / 8;

    typedef struct packed {
        logic [OBI_ADDR_W-1:0] addr;
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_DATA_W-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic [OBI_DATA_W-1:0] rdata;
        logic                  err;
    } obi_rsp_t;

    // Per-transaction bookkeeping carried alongside the memory read latency.
    typedef struct packed {
        logic valid;
        logic we;
        logic err;
    } resp_tag_t;

endpackage

// File: rtl/obi_resp_pipe.sv
// Fixed-depth shift pipeline of response tags; one entry enters and one retires every cycle.
module obi_resp_pipe
    import obi_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  resp_tag_t tag_i,
    output resp_tag_t tag_o
);

    resp_tag_t tag_q [DEPTH];
    resp_tag_t tag_d [DEPTH];

    always_comb begin
        tag_d[0] = tag_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign tag_o = tag_q[DEPTH-1];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI slave front-end for a synchronous SRAM: grant wait-states, access checking,
// single-cycle memory strobes and in-order responses after a fixed read latency.
module obi_mem_responder
    import obi_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                obi_req_i,
    output logic                obi_gnt_o,
    input  logic [ADDR_W-1:0]   obi_addr_i,
    input  logic                obi_we_i,
    input  logic [DATA_W/8-1:0] obi_be_i,
    input  logic [DATA_W-1:0]   obi_wdata_i,
    output logic                obi_rvalid_o,
    output logic [DATA_W-1:0]   obi_rdata_o,
    output logic                obi_err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned BE_W  = DATA_W / 8;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             handshake;
    logic             access_err;
    resp_tag_t        tag_in, tag_out;

    // Grant only once req has been held for WAIT_CYCLES cycles; forced low during reset.
    always_comb begin
        obi_gnt_o  = obi_req_i & rst_ni & (wait_cnt_q == CNT_W'(WAIT_CYCLES));
        handshake  = obi_req_i & obi_gnt_o;
        access_err = (obi_addr_i[1:0] != 2'b00) | (obi_be_i == '0);
    end

    // A dropped request forgets any accumulated wait.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!obi_req_i || handshake) begin
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Memory side sees only clean accesses, zeroed when idle.
    always_comb begin
        mem_req_o   = handshake & ~access_err;
        mem_we_o    = 1'b0;
        mem_be_o    = BE_W'(0);
        mem_addr_o  = ADDR_W'(0);
        mem_wdata_o = DATA_W'(0);
        if (mem_req_o) begin
            mem_we_o    = obi_we_i;
            mem_be_o    = obi_be_i;
            mem_addr_o  = obi_addr_i;
            mem_wdata_o = obi_wdata_i;
        end
    end

    always_comb begin
        tag_in.valid = handshake;
        tag_in.we    = handshake & obi_we_i;
        tag_in.err   = handshake & access_err;
    end

    obi_resp_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tag_i  (tag_in),
        .tag_o  (tag_out)
    );

    // Read data is only forwarded for successful reads.
    always_comb begin
        obi_rvalid_o = tag_out.valid;
        obi_err_o    = tag_out.valid & tag_out.err;
        obi_rdata_o  = DATA_W'(0);
        if (tag_out.valid && !tag_out.we && !tag_out.err) begin
            obi_rdata_o = mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Scoreboard bench for obi_mem_responder: three instances with different wait/latency
// settings, a behavioural SRAM behind each, and in-order expected-response queues.
module tb_obi_mem_responder;

    localparam int unsigned NDUT = 3;
    localparam int unsigned WAITV [NDUT] = '{0, 0, 3};
    localparam int unsigned LATV  [NDUT] = '{1, 3, 2};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req    [NDUT];
    logic        gnt    [NDUT];
    logic [31:0] addr   [NDUT];
    logic        we     [NDUT];
    logic [3:0]  be     [NDUT];
    logic [31:0] wdata  [NDUT];
    logic        rvalid [NDUT];
    logic [31:0] rdata  [NDUT];
    logic        err    [NDUT];
    logic        mreq   [NDUT];
    logic        mwe    [NDUT];
    logic [3:0]  mbe    [NDUT];
    logic [31:0] maddr  [NDUT];
    logic [31:0] mwdata [NDUT];
    logic [31:0] mrdata [NDUT];

    exp_t        sb     [NDUT][$];
    logic [31:0] shadow [NDUT][64];
    logic [31:0] ram    [NDUT][64];
    logic [31:0] rpipe  [NDUT][4];
    logic        rpv    [NDUT][4];
    int unsigned wcnt   [NDUT];
    int unsigned cyc;
    int          n_checks;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obi_mem_responder #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WAITV[0]), .MEM_LATENCY(LATV[0])) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req[0]), .obi_gnt_o(gnt[0]), .obi_addr_i(addr[0]),
        .obi_we_i(we[0]), .obi_be_i(be[0]), .obi_wdata_i(wdata[0]), .obi_rvalid_o(rvalid[0]),
        .obi_rdata_o(rdata[0]), .obi_err_o(err[0]), .mem_req_o(mreq[0]), .mem_we_o(mwe[0]),
        .mem_be_o(mbe[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwdata[0]), .mem_rdata_i(mrdata[0]));

    obi_mem_responder #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WAITV[1]), .MEM_LATENCY(LATV[1])) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req[1]), .obi_gnt_o(gnt[1]), .obi_addr_i(addr[1]),
        .obi_we_i(we[1]), .obi_be_i(be[1]), .obi_wdata_i(wdata[1]), .obi_rvalid_o(rvalid[1]),
        .obi_rdata_o(rdata[1]), .obi_err_o(err[1]), .mem_req_o(mreq[1]), .mem_we_o(mwe[1]),
        .mem_be_o(mbe[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwdata[1]), .mem_rdata_i(mrdata[1]));

    obi_mem_responder #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WAITV[2]), .MEM_LATENCY(LATV[2])) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req[2]), .obi_gnt_o(gnt[2]), .obi_addr_i(addr[2]),
        .obi_we_i(we[2]), .obi_be_i(be[2]), .obi_wdata_i(wdata[2]), .obi_rvalid_o(rvalid[2]),
        .obi_rdata_o(rdata[2]), .obi_err_o(err[2]), .mem_req_o(mreq[2]), .mem_we_o(mwe[2]),
        .mem_be_o(mbe[2]), .mem_addr_o(maddr[2]), .mem_wdata_o(mwdata[2]), .mem_rdata_i(mrdata[2]));

    function automatic logic [31:0] init_val(input int d, input int i);
        if (d == 0 && i == 1) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 | 32'(d << 12) | 32'(i * 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Behavioural SRAM: reads return data MEM_LATENCY cycles after the strobe, junk otherwise.
    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (!rst_n) begin
                for (int i = 0; i < 64; i++) ram[d][i] <= init_val(d, i);
                for (int k = 0; k < 4; k++) rpv[d][k] <= 1'b0;
            end else begin
                for (int k = 1; k < 4; k++) begin
                    rpipe[d][k] <= rpipe[d][k-1];
                    rpv[d][k]   <= rpv[d][k-1];
                end
                rpipe[d][0] <= ram[d][maddr[d][7:2]];
                rpv[d][0]   <= mreq[d] & ~mwe[d];
                if (mreq[d] && mwe[d]) begin
                    ram[d][maddr[d][7:2]] <= merge(ram[d][maddr[d][7:2]], mwdata[d], mbe[d]);
                end
            end
        end
    end

    always_comb begin
        for (int d = 0; d < NDUT; d++) begin
            mrdata[d] = rpv[d][LATV[d]-1] ? rpipe[d][LATV[d]-1] : 32'hBADC_0FFE;
        end
    end

    task automatic monitor_one(input int d);
        logic        eg;
        logic        e;
        int          idx;
        exp_t        x;
        eg = req[d] && (wcnt[d] == WAITV[d]);
        e  = (addr[d][1:0] != 2'b00) || (be[d] == 4'h0);
        check_eq($sformatf("d%0d gnt", d), 32'(gnt[d]), 32'(eg));
        if (eg) begin
            check_eq($sformatf("d%0d mem_req", d), 32'(mreq[d]), 32'(!e));
            if (!e) begin
                check_eq($sformatf("d%0d mem_addr", d), maddr[d], addr[d]);
                check_eq($sformatf("d%0d mem_we_be", d), 32'({mwe[d], mbe[d]}), 32'({we[d], be[d]}));
                check_eq($sformatf("d%0d mem_wdata", d), mwdata[d], wdata[d]);
            end
            idx     = int'(addr[d][7:2]);
            x.rdata = (we[d] || e) ? 32'h0 : shadow[d][idx];
            x.err   = e;
            x.due   = cyc + LATV[d];
            if (we[d] && !e) shadow[d][idx] = merge(shadow[d][idx], wdata[d], be[d]);
            sb[d].push_back(x);
        end else begin
            check_eq($sformatf("d%0d mem_req idle", d), 32'(mreq[d]), 32'h0);
            check_eq($sformatf("d%0d mem bus idle", d),
                     maddr[d] | mwdata[d] | 32'({mwe[d], mbe[d]}), 32'h0);
        end
        wcnt[d] = (!req[d] || eg) ? 0 : wcnt[d] + 1;

        if (rvalid[d]) begin
            if (sb[d].size() == 0) begin
                check_eq($sformatf("d%0d spurious rvalid", d), 32'h1, 32'h0);
            end else begin
                x = sb[d].pop_front();
                check_eq($sformatf("d%0d rsp timing", d), cyc, x.due);
                check_eq($sformatf("d%0d rdata", d), rdata[d], x.rdata);
                check_eq($sformatf("d%0d err", d), 32'(err[d]), 32'(x.err));
            end
        end else begin
            check_eq($sformatf("d%0d idle rsp", d), rdata[d] | 32'(err[d]), 32'h0);
            if (sb[d].size() != 0 && sb[d][0].due <= cyc) begin
                check_eq($sformatf("d%0d missing rvalid", d), 32'h0, 32'h1);
                void'(sb[d].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (!rst_n) begin
                sb[d].delete();
                wcnt[d] = 0;
                for (int i = 0; i < 64; i++) shadow[d][i] = init_val(d, i);
                check_eq($sformatf("d%0d reset outs", d),
                         32'({gnt[d], rvalid[d], mreq[d], err[d]}) | rdata[d], 32'h0);
            end else begin
                monitor_one(d);
            end
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one request and hold it until the cycle it should be granted.
    task automatic issue(input int d, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] wd);
        req[d]   = 1'b1;
        addr[d]  = a;
        we[d]    = w;
        be[d]    = b;
        wdata[d] = wd;
        tick(int'(WAITV[d]) + 1);
    endtask

    task automatic idle(input int d, input int n);
        req[d]   = 1'b0;
        addr[d]  = 32'h0;
        we[d]    = 1'b0;
        be[d]    = 4'h0;
        wdata[d] = 32'h0;
        tick(n);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  b;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            req[d] = 1'b0; addr[d] = 32'h0; we[d] = 1'b0; be[d] = 4'h0; wdata[d] = 32'h0;
            wcnt[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);

        // Single read, zero wait, latency 1
        issue(0, 32'h1000_0004, 1'b0, 4'hF, 32'h0);
        idle(0, 3);

        // Back-to-back writes then read-back, latency 3
        for (int k = 0; k < 4; k++) issue(1, 32'(k * 4), 1'b1, 4'hF, 32'h1111_1111 * 32'(k + 1));
        issue(1, 32'h10, 1'b1, 4'b0101, 32'hAABB_CCDD);
        issue(1, 32'h4, 1'b0, 4'hF, 32'h0);
        issue(1, 32'h10, 1'b0, 4'hF, 32'h0);
        issue(1, 32'h3C, 1'b0, 4'hF, 32'h0);
        idle(1, 5);

        // Wait states: normal read, abandoned request, then write/read pair
        issue(2, 32'h20, 1'b0, 4'hF, 32'h0);
        idle(2, 1);
        req[2] = 1'b1; addr[2] = 32'h24; be[2] = 4'hF;
        tick(2);
        idle(2, 1);
        issue(2, 32'h24, 1'b1, 4'hC, 32'h5566_7788);
        issue(2, 32'h24, 1'b0, 4'hF, 32'h0);
        idle(2, 4);

        // Access errors: misaligned read, zero-byte write, then confirm nothing was written
        issue(0, 32'h2, 1'b0, 4'hF, 32'h0);
        issue(0, 32'h8, 1'b1, 4'h0, 32'hFFFF_FFFF);
        issue(0, 32'h8, 1'b0, 4'hF, 32'h0);
        idle(0, 3);
        issue(2, 32'h13, 1'b0, 4'hF, 32'h0);
        idle(2, 4);

        // Mixed random stream, latency 3
        for (int i = 0; i < 20; i++) begin
            a = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
            b = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            issue(1, a, 1'($urandom_range(0, 1)), b, $urandom);
        end
        idle(1, 5);

        // Reset with two responses in flight
        issue(1, 32'h8, 1'b0, 4'hF, 32'h0);
        issue(1, 32'hC, 1'b0, 4'hF, 32'h0);
        idle(1, 1);
        check_eq("pre-reset rvalid", 32'(rvalid[1]), 32'h1);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check_eq($sformatf("d%0d async reset", d),
                     32'({gnt[d], rvalid[d], mreq[d], err[d]}) | rdata[d], 32'h0);
        end
        tick(2);
        rst_n = 1'b1;
        idle(1, 6);
        issue(1, 32'h4, 1'b0, 4'hF, 32'h0);
        idle(1, 5);

        for (int d = 0; d < NDUT; d++) idle(d, 0);
        tick(4);
        for (int d = 0; d < NDUT; d++) begin
            check_eq($sformatf("d%0d drained", d), 32'(sb[d].size()), 32'h0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
